// File: rtl/vlog_tb_pkg.sv
// Shared definitions for the stream checker: FSM state encoding and the
// default watchdog length used when VLOG_STREAM_CHECKER_TIMEOUT_EN is defined.
package vlog_tb_pkg;

  // IDLE waits for a start pulse, RUN compares beats, REPORT emits the verdict.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Idle cycles in RUN before a testcase is aborted by the watchdog.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

endpackage

// File: rtl/vlog_stream_checker_if.sv
// Bus bundle for vlog_stream_checker: expected-value stream, DUT stream under
// check and the per-testcase verdict.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high; the source holds valid and data stable
// until that edge; ready never depends on valid in the same cycle.
interface vlog_stream_checker_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) ();

  logic             exp_valid;
  logic             exp_ready;
  logic [DW-1:0]    exp_data;

  logic             dut_valid;
  logic             dut_ready;
  logic [DW-1:0]    dut_data;

  logic             res_valid;
  logic             res_ok;
  logic [CNT_W-1:0] res_index;
  logic [CNT_W-1:0] res_errors;
  logic             res_timeout;

  // Stimulus side: sources both streams and consumes verdicts.
  modport master (
    output exp_valid, exp_data, dut_valid, dut_data,
    input  exp_ready, dut_ready,
    input  res_valid, res_ok, res_index, res_errors, res_timeout
  );

  // Checker side: sinks both streams and produces verdicts.
  modport slave (
    input  exp_valid, exp_data, dut_valid, dut_data,
    output exp_ready, dut_ready,
    output res_valid, res_ok, res_index, res_errors, res_timeout
  );

endinterface

// File: rtl/vlog_stream_checker_fifo.sv
// vlog_sync_fifo: synchronous FIFO holding expected values. Storage is a
// register array; the head entry is presented from those registers, so a
// pushed word becomes visible (empty deasserts) the cycle after the push.
// Flush is synchronous and has priority over push and pop.
module vlog_sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update: flush empties the buffer, otherwise advance on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vlog_stream_checker.sv
// vlog_stream_checker: compares a DUT output stream beat-by-beat against a
// buffered expected stream and emits one verdict per testcase.
// Optional watchdog: define VLOG_STREAM_CHECKER_TIMEOUT_EN to abort a
// testcase after TIMEOUT_CYCLES idle cycles in RUN.
module vlog_stream_checker
  import vlog_tb_pkg::*;
#(
  parameter int          DW             = 32,
  parameter int          CNT_W          = 16,
  parameter int          FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tc_start,
  input  logic [CNT_W-1:0]     tc_len,
  vlog_stream_checker_if.slave bus,
  output logic                 busy,
  output state_t               dbg_state
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_beats;
  logic [CNT_W-1:0] r_errors;
  logic [CNT_W-1:0] r_index;
  logic [CNT_W-1:0] w_beats_next;
  logic [DW-1:0]    w_head;
  logic             w_run;
  logic             w_report;
  logic             w_start;
  logic             w_full;
  logic             w_empty;
  logic             w_exp_hs;
  logic             w_dut_hs;
  logic             w_done;
  logic             w_mismatch;
  logic             w_timeout;
  logic             w_timeout_fire;

  assign w_run    = (r_state == ST_RUN);
  assign w_report = (r_state == ST_REPORT);
  assign w_start  = (r_state == ST_IDLE) && tc_start;

  // No bypass: a DUT beat only handshakes against an entry already stored.
  assign w_exp_hs = bus.exp_valid && w_run && !w_full;
  assign w_dut_hs = bus.dut_valid && w_run && !w_empty;

  // Look at the count including this cycle's beat so the verdict follows the
  // final handshake by exactly one cycle.
  assign w_beats_next = r_beats + {{(CNT_W-1){1'b0}}, w_dut_hs};
  assign w_done       = w_run && (w_beats_next == r_len);

  // Four-state compare: X or Z on either side is a mismatch.
  assign w_mismatch = (bus.dut_data !== w_head);

  vlog_sync_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_exp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_report),
    .i_push  (w_exp_hs),
    .i_data  (bus.exp_data),
    .i_pop   (w_dut_hs),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic; REPORT always lasts a single cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (tc_start) w_state_next = ST_RUN;
      ST_RUN:    if (w_done || w_timeout_fire) w_state_next = ST_REPORT;
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stream readiness, verdict fields and status.
  always_comb begin
    bus.exp_ready   = w_run && !w_full;
    bus.dut_ready   = w_run && !w_empty;
    bus.res_valid   = w_report;
    bus.res_ok      = w_report && (r_errors == '0) && w_empty && !w_timeout;
    bus.res_index   = r_index;
    bus.res_errors  = r_errors;
    bus.res_timeout = w_timeout;
    busy            = (r_state != ST_IDLE);
    dbg_state       = r_state;
  end

  // Testcase bookkeeping: latch length, count beats and saturating errors,
  // pre-increment the 1-based testcase index on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_beats  <= '0;
      r_errors <= '0;
      r_index  <= '0;
    end else if (w_start) begin
      r_len    <= tc_len;
      r_beats  <= '0;
      r_errors <= '0;
      r_index  <= r_index + 1'b1;
    end else if (w_dut_hs) begin
      r_beats <= w_beats_next;
      if (w_mismatch && (r_errors != {CNT_W{1'b1}})) r_errors <= r_errors + 1'b1;
    end
  end

`ifdef VLOG_STREAM_CHECKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_timeout;

  // Fires after TIMEOUT_CYCLES consecutive RUN cycles without a DUT beat.
  assign w_timeout_fire = w_run && !w_dut_hs &&
                          (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout      = r_timeout;

  // Watchdog: idle counter restarts on RUN entry and on every DUT beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_start) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_run) begin
      if (w_dut_hs) r_idle_cnt <= '0;
      else          r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_timeout_fire) r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_timeout_fire       = 1'b0;
  assign w_timeout            = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_vlog_stream_checker.sv
// Bench for vlog_stream_checker: directed and random testcases; expected
// verdicts come from a simple per-testcase model and are checked by a
// monitor that pops a queue on every res_valid.
module tb_vlog_stream_checker;
  import vlog_tb_pkg::*;

  localparam int DW    = 32;
  localparam int CNT_W = 16;
  localparam int W     = 2 + 2 * CNT_W;
`ifdef VLOG_STREAM_CHECKER_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1000;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tc_start = 1'b0;
  logic [CNT_W-1:0] tc_len = '0;
  logic             busy;
  state_t           dbg_state;

  vlog_stream_checker_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  vlog_stream_checker #(
    .DW             (DW),
    .CNT_W          (CNT_W),
    .FIFO_AW        (3),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tc_start  (tc_start),
    .tc_len    (tc_len),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  logic [CNT_W-1:0] tc_num = '0;
  logic [DW-1:0]    e_arr [16];
  logic [DW-1:0]    d_arr [16];
  bit               x_arr [16];
  int               ne, nd, dut_stall, pushed_cnt;
  bit               exp_gaps, dut_gaps, bp_check;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_tc(input logic [CNT_W-1:0] len);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    if (busy !== 1'b0) check("start_wait_busy", busy, 0);
    tc_start = 1'b1;
    tc_len   = len;
    tick();
    tc_start = 1'b0;
    tc_num   = tc_num + 1'b1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    int n = 0;
    bus.exp_valid = 1'b1;
    bus.exp_data  = d;
    do begin @(negedge clk); n++; end while (bus.exp_ready !== 1'b1 && n < 500);
    if (bus.exp_ready !== 1'b1) check("exp_ready_wait", bus.exp_ready, 1);
    @(posedge clk);
    #1;
    bus.exp_valid = 1'b0;
    pushed_cnt++;
  endtask

  task automatic push_dut(input logic [DW-1:0] d, input bit is_x);
    int n = 0;
    bus.dut_valid = 1'b1;
    if (is_x) bus.dut_data = 'x;
    else      bus.dut_data = d;
    do begin @(negedge clk); n++; end while (bus.dut_ready !== 1'b1 && n < 500);
    if (bus.dut_ready !== 1'b1) check("dut_ready_wait", bus.dut_ready, 1);
    @(posedge clk);
    #1;
    bus.dut_valid = 1'b0;
  endtask

  // Gaps are placed before each beat so the last beat ends each stream.
  task automatic drive_exp_all();
    for (int i = 0; i < ne; i++) begin
      if (exp_gaps) repeat ($urandom_range(0, 1)) tick();
      push_exp(e_arr[i]);
    end
  endtask

  task automatic drive_dut_all();
    repeat (dut_stall) tick();
    if (bp_check) begin
      @(negedge clk);
      check("bp_exp_accepted", pushed_cnt, 8);
      check("bp_exp_ready_low", bus.exp_ready, 0);
      tick();
    end
    for (int i = 0; i < nd; i++) begin
      if (dut_gaps) repeat ($urandom_range(0, 2)) tick();
      push_dut(d_arr[i], x_arr[i]);
    end
  endtask

  // Model: beat i of the DUT is judged against expected beat i; the case
  // passes only with no mismatches, no unconsumed expected beats and no
  // watchdog abort.
  task automatic run_tc(input logic [CNT_W-1:0] len, input bit seq, input bit exp_to);
    int errs = 0;
    bit ok;
    int n, cyc;
    for (int i = 0; i < nd; i++)
      if (x_arr[i] || (d_arr[i] !== e_arr[i])) errs++;
    ok = (errs == 0) && (ne == nd) && !exp_to;
    exp_q.push_back({exp_to, ok, CNT_W'(errs), tc_num + 1'b1});
    pushed_cnt = 0;
    start_tc(len);
    if (seq) begin
      drive_exp_all();
      drive_dut_all();
    end else begin
      fork
        drive_exp_all();
        drive_dut_all();
      join
    end
    if (exp_to) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (bus.res_valid !== 1'b1 && cyc < 3 * TO);
      check("timeout_latency", cyc, TO + 1);
      tick();
    end else if (nd == int'(len) && len != 0) begin
      @(negedge clk);
      check("res_latency", bus.res_valid, 1);
      @(negedge clk);
      check("busy_clear", busy, 0);
      tick();
    end
    n = 0;
    while (busy !== 1'b0 && n < 3 * TO + 100) begin tick(); n++; end
    if (busy !== 1'b0) check("verdict_wait_busy", busy, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_verdict actual=res_valid required=no_verdict");
        end else begin
          e = exp_q.pop_front();
          check("res_index",   bus.res_index,   e[CNT_W-1:0]);
          check("res_errors",  bus.res_errors,  e[2*CNT_W-1:CNT_W]);
          check("res_ok",      bus.res_ok,      e[2*CNT_W]);
          check("res_timeout", bus.res_timeout, e[2*CNT_W+1]);
          check("report_readies_low", {bus.exp_ready, bus.dut_ready}, 0);
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.exp_valid = 1'b0;
    bus.exp_data  = '0;
    bus.dut_valid = 1'b0;
    bus.dut_data  = '0;
    exp_gaps = 0; dut_gaps = 0; bp_check = 0; dut_stall = 0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid",   bus.res_valid, 0);
    check("rst_res_ok",      bus.res_ok, 0);
    check("rst_res_timeout", bus.res_timeout, 0);
    check("rst_busy",        busy, 0);
    check("rst_exp_ready",   bus.exp_ready, 0);
    check("rst_dut_ready",   bus.dut_ready, 0);
    check("rst_res_errors",  bus.res_errors, 0);
    check("rst_res_index",   bus.res_index, 0);
    check("rst_state",       dbg_state, ST_IDLE);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_exp_ready", bus.exp_ready, 0);

    // pass: 4 matching beats
    ne = 4; nd = 4;
    e_arr[0] = 32'h11; e_arr[1] = 32'h22; e_arr[2] = 32'h33; e_arr[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin d_arr[i] = e_arr[i]; x_arr[i] = 0; end
    run_tc(4, 0, 0);

    // mismatch: data error then X
    ne = 3; nd = 3;
    e_arr[0] = 32'h1111; e_arr[1] = 32'hBEEF; e_arr[2] = 32'h1234_5678;
    d_arr[0] = 32'h1111; d_arr[1] = 32'hDEAD; d_arr[2] = 32'h0;
    x_arr[0] = 0; x_arr[1] = 0; x_arr[2] = 1;
    run_tc(3, 0, 0);

    // backpressure: 12 beats, DUT stalled 20 cycles
    ne = 12; nd = 12;
    for (int i = 0; i < 12; i++) begin e_arr[i] = $urandom; d_arr[i] = e_arr[i]; x_arr[i] = 0; end
    dut_stall = 20; bp_check = 1;
    run_tc(12, 0, 0);
    dut_stall = 0; bp_check = 0;

    // reset in the middle of RUN
    start_tc(5);
    push_exp(32'hA);
    push_exp(32'hB);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy",       busy, 0);
    check("midrst_res_valid",  bus.res_valid, 0);
    check("midrst_exp_ready",  bus.exp_ready, 0);
    check("midrst_dut_ready",  bus.dut_ready, 0);
    check("midrst_res_index",  bus.res_index, 0);
    check("midrst_res_errors", bus.res_errors, 0);
    check("midrst_res_ok",     bus.res_ok, 0);
    tick();
    rst_n  = 1'b1;
    tc_num = '0;
    repeat (3) tick();

    // leftover expected beat: fails with zero errors, index 1
    ne = 3; nd = 2;
    for (int i = 0; i < 3; i++) begin e_arr[i] = 32'h100 + i; d_arr[i] = e_arr[i]; x_arr[i] = 0; end
    run_tc(2, 1, 0);

    // zero length: passes, index 2
    ne = 0; nd = 0;
    run_tc(0, 0, 0);

`ifdef VLOG_STREAM_CHECKER_TIMEOUT_EN
    // watchdog: 5 beats requested, only 2 delivered
    ne = 2; nd = 2;
    for (int i = 0; i < 2; i++) begin e_arr[i] = $urandom; d_arr[i] = e_arr[i]; x_arr[i] = 0; end
    run_tc(5, 0, 1);
`endif

    // randomized testcases
    exp_gaps = 1; dut_gaps = 1;
    for (int t = 0; t < 10; t++) begin
      int len;
      len = $urandom_range(1, 10);
      ne = len; nd = len;
      for (int i = 0; i < len; i++) begin
        e_arr[i] = $urandom;
        x_arr[i] = 0;
        if ($urandom_range(0, 3) == 0) d_arr[i] = e_arr[i] ^ (32'd1 << $urandom_range(0, 31));
        else                           d_arr[i] = e_arr[i];
      end
      dut_stall = $urandom_range(0, 3);
      run_tc(CNT_W'(len), 0, 0);
    end

    repeat (5) tick();
    check("pending_verdicts", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
